seg7_digit_monitor: RTL and testbench

- Receiving end of the 7-segment digit interface: samples an active-low 7-bit segment bus and accepts a pattern only once it has been stable long enough.
- Decodes the accepted pattern back to a BCD digit.
- Classifies each digit change as step, skip or zero, counts 9->0 wraps, and flags illegal patterns.
- Used as an on-board checker and bench monitor for stopwatch/counter display outputs.

---
 rtl/seg7_digit_monitor.sv | 179 +++++++++++++++++
 tb/tb_seg7_digit_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_monitor.sv
// Receive-side checker for an active-low 7-segment digit bus: debounce, decode, classify changes.
// Optional: define SEG7_STEP_PERIOD_EN to measure cycles between consecutive Step pulses on Period.
module seg7_digit_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned WRAP_W        = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Clear,
  input  logic [6:0]        Segments,
  output logic [3:0]        Digit,
  output logic              DigitValid,
  output logic              Step,
  output logic              Skip,
  output logic              Zero,
  output logic              Invalid,
  output logic [WRAP_W-1:0] Wraps,
  output logic [31:0]       Period
);

  localparam int unsigned    CNT_W      = 8;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]     SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  // {legal, digit} for an active-low pattern, bit6=g .. bit0=a
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [6:0]       s0, s1;
  logic [CNT_W-1:0] stable_cnt, stable_nxt;
  logic             accept_c;
  logic [4:0]       dec;
  logic [3:0]       prev_inc;

  state_t           state_q, state_d;
  logic [3:0]       digit_d;
  logic             dv_d, step_d, skip_d, zero_d, invalid_d;
  logic [WRAP_W-1:0] wraps_d;
  logic             have_last_q, have_last_d;
  logic [6:0]       last_pat_q, last_pat_d;

  // Two-stage sampler and stability counter
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s0         <= SEG_BLANK;
      s1         <= SEG_BLANK;
      stable_cnt <= '0;
    end else begin
      s0         <= Segments;
      s1         <= s0;
      stable_cnt <= stable_nxt;
    end
  end

  // Accept fires on the edge where the count reaches its final value
  always_comb begin
    stable_nxt = '0;
    if (Enable && !Clear && (s0 == s1)) begin
      stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
    accept_c = Enable && (s0 == s1) && (stable_nxt == STABLE_MAX) &&
               (!have_last_q || (s0 != last_pat_q));
  end

  assign dec      = decode(s0);
  assign prev_inc = (Digit == 4'd9) ? 4'd0 : Digit + 4'd1;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    digit_d     = Digit;
    dv_d        = 1'b0;
    step_d      = 1'b0;
    skip_d      = 1'b0;
    zero_d      = 1'b0;
    invalid_d   = Invalid;
    wraps_d     = Wraps;
    have_last_d = have_last_q;
    last_pat_d  = last_pat_q;

    if (Clear) begin
      state_d     = IDLE;
      invalid_d   = 1'b0;
      wraps_d     = '0;
      have_last_d = 1'b0;
      last_pat_d  = SEG_BLANK;
    end else if (accept_c) begin
      have_last_d = 1'b1;
      last_pat_d  = s0;
      if (!dec[4]) begin
        state_d   = FAULT;
        invalid_d = 1'b1;
      end else begin
        state_d = TRACK;
        digit_d = dec[3:0];
        dv_d    = 1'b1;
        if (state_q == TRACK) begin
          if (dec[3:0] == prev_inc) begin
            step_d = 1'b1;
            if ((Digit == 4'd9) && (Wraps != '1)) wraps_d = Wraps + WRAP_W'(1);
          end else if (dec[3:0] == 4'd0) begin
            zero_d = 1'b1;
          end else begin
            skip_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      Digit       <= '0;
      DigitValid  <= 1'b0;
      Step        <= 1'b0;
      Skip        <= 1'b0;
      Zero        <= 1'b0;
      Invalid     <= 1'b0;
      Wraps       <= '0;
      have_last_q <= 1'b0;
      last_pat_q  <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      Digit       <= digit_d;
      DigitValid  <= dv_d;
      Step        <= step_d;
      Skip        <= skip_d;
      Zero        <= zero_d;
      Invalid     <= invalid_d;
      Wraps       <= wraps_d;
      have_last_q <= have_last_d;
      last_pat_q  <= last_pat_d;
    end
  end

`ifdef SEG7_STEP_PERIOD_EN
  logic [31:0] step_cnt;
  logic        seen_step;

  // Cycle counter restarts at 1 on every Step; Period latches the gap between Steps
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      step_cnt  <= '0;
      seen_step <= 1'b0;
      Period    <= '0;
    end else if (Clear) begin
      step_cnt  <= '0;
      seen_step <= 1'b0;
      Period    <= '0;
    end else if (step_d) begin
      step_cnt  <= 32'd1;
      seen_step <= 1'b1;
      if (seen_step) Period <= step_cnt;
    end else if (step_cnt != '1) begin
      step_cnt <= step_cnt + 32'd1;
    end
  end
`else
  assign Period = '0;
`endif

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Scoreboard bench for seg7_digit_monitor: expected accepts are queued when patterns are driven.
module tb_seg7_digit_monitor;

  localparam int unsigned SC = 4;
  localparam int unsigned WW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Enable = 1'b0;
  logic          Clear = 1'b0;
  logic [6:0]    Segments = 7'b1111111;
  logic [3:0]    Digit;
  logic          DigitValid, Step, Skip, Zero, Invalid;
  logic [WW-1:0] Wraps;
  logic [31:0]   Period;

  seg7_digit_monitor #(.STABLE_CYCLES(SC), .WRAP_W(WW)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Clear(Clear), .Segments(Segments),
    .Digit(Digit), .DigitValid(DigitValid), .Step(Step), .Skip(Skip), .Zero(Zero),
    .Invalid(Invalid), .Wraps(Wraps), .Period(Period)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] d;
    logic       st;
    logic       sk;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: 0 idle, 1 tracking, 2 fault
  int   m_state = 0;
  int   m_prev  = 0;
  int   m_wraps = 0;
  logic prev_dv = 1'b0;

  function automatic void expect_digit(input int d);
    exp_t e;
    int   nx;
    e = '{d: 4'(d), st: 1'b0, sk: 1'b0, z: 1'b0};
    if (m_state == 1) begin
      nx = (m_prev == 9) ? 0 : m_prev + 1;
      if (d == nx) begin
        e.st = 1'b1;
        if (m_prev == 9 && m_wraps < 65535) m_wraps++;
      end else if (d == 0) e.z = 1'b1;
      else e.sk = 1'b1;
    end
    m_state = 1;
    m_prev  = d;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    Segments = p;
    tick(n);
  endtask

  task automatic drive_digit(input int d, input int n);
    expect_digit(d);
    hold(seg_tab[d], n);
  endtask

  // Pop the scoreboard whenever any pulse output is seen
  always @(negedge Clock) begin
    exp_t e;
    if (Reset && (DigitValid || Step || Skip || Zero)) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse dv=%b digit=%0d st=%b sk=%b z=%b, required none",
                 DigitValid, Digit, Step, Skip, Zero);
      end else begin
        e = sb.pop_front();
        if ({DigitValid, Digit, Step, Skip, Zero} !== {1'b1, e.d, e.st, e.sk, e.z})
          $display("FAIL accept dv=%b digit=%0d st=%b sk=%b z=%b, required dv=1 digit=%0d st=%b sk=%b z=%b",
                   DigitValid, Digit, Step, Skip, Zero, e.d, e.st, e.sk, e.z);
        else passes++;
      end
      checks++;
      if (prev_dv !== 1'b0) $display("FAIL pulse_back_to_back prev_dv=%b, required 0", prev_dv);
      else passes++;
    end
    prev_dv = DigitValid;
  end

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) $display("FAIL %s_drained pending=%0d, required 0", name, sb.size());
    else passes++;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Enable = 1'b1; Segments = seg_tab[0];
    tick(2);
    checks++;
    if ({Digit, DigitValid, Step, Skip, Zero, Invalid, Wraps, Period} !== '0)
      $display("FAIL reset_state digit=%0d dv=%b inv=%b wraps=%0d period=%0d, required all 0",
               Digit, DigitValid, Invalid, Wraps, Period);
    else passes++;
    expect_digit(0);
    Reset = 1'b1;
    for (int i = 0; i <= SC; i++) begin
      tick(1);
      checks++;
      if (DigitValid !== (i == SC)) $display("FAIL first_latency edge=%0d dv=%b, required %b", i, DigitValid, i == SC);
      else passes++;
    end
    tick(5);
    check_drained("reset");
  endtask

  task automatic test_count;
    for (int d = 1; d <= 10; d++) drive_digit(d % 10, 10);
    checks++;
    if (Digit !== 4'd0 || Wraps !== WW'(m_wraps) || m_wraps != 1)
      $display("FAIL count_wrap digit=%0d wraps=%0d, required digit=0 wraps=1", Digit, Wraps);
    else passes++;
    check_drained("count");
  endtask

  task automatic test_glitch;
    for (int d = 1; d <= 3; d++) drive_digit(d, 10);
    hold(seg_tab[4], 2);
    hold(seg_tab[3], 10);
    checks++;
    if (Digit !== 4'd3) $display("FAIL glitch_digit got=%0d, required 3", Digit);
    else passes++;
    check_drained("glitch");
  endtask

  task automatic test_skip_zero;
    drive_digit(2, 10);
    drive_digit(7, 10);
    drive_digit(0, 10);
    checks++;
    if (Wraps !== WW'(1)) $display("FAIL skip_zero_wraps got=%0d, required 1", Wraps);
    else passes++;
    check_drained("skip_zero");
  endtask

  task automatic test_invalid_clear;
    hold(7'b1111111, 8);
    m_state = 2;
    checks++;
    if (Invalid !== 1'b1 || Digit !== 4'd0) $display("FAIL invalid_set inv=%b digit=%0d, required inv=1 digit=0", Invalid, Digit);
    else passes++;
    drive_digit(9, 10);
    checks++;
    if (Invalid !== 1'b1 || Digit !== 4'd9) $display("FAIL invalid_sticky inv=%b digit=%0d, required inv=1 digit=9", Invalid, Digit);
    else passes++;
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    m_state = 0; m_wraps = 0;
    checks++;
    if (Invalid !== 1'b0 || Wraps !== '0 || Period !== '0 || Digit !== 4'd9)
      $display("FAIL clear inv=%b wraps=%0d period=%0d digit=%0d, required inv=0 wraps=0 period=0 digit=9",
               Invalid, Wraps, Period, Digit);
    else passes++;
    expect_digit(9);
    tick(10);
    check_drained("invalid_clear");
  endtask

  task automatic test_enable;
    Enable = 1'b0;
    hold(seg_tab[5], 10);
    expect_digit(5);
    Enable = 1'b1;
    for (int i = 1; i <= SC - 1; i++) begin
      tick(1);
      checks++;
      if (DigitValid !== (i == SC - 1)) $display("FAIL enable_window edge=%0d dv=%b, required %b", i, DigitValid, i == SC - 1);
      else passes++;
    end
    tick(5);
    check_drained("enable");
  endtask

  task automatic test_back_to_back;
    for (int d = 6; d <= 8; d++) drive_digit(d, SC);
    hold(seg_tab[8], 6);
    checks++;
    if (Digit !== 4'd8) $display("FAIL back_to_back_digit got=%0d, required 8", Digit);
    else passes++;
    check_drained("back_to_back");
  endtask

  task automatic test_period;
    drive_digit(9, 20);
    drive_digit(0, 20);
    drive_digit(1, 20);
    checks++;
`ifdef SEG7_STEP_PERIOD_EN
    if (Period !== 32'd20) $display("FAIL period got=%0d, required 20", Period);
    else passes++;
`else
    if (Period !== 32'd0) $display("FAIL period_tied got=%0d, required 0", Period);
    else passes++;
`endif
    checks++;
    if (Wraps !== WW'(m_wraps)) $display("FAIL period_wraps got=%0d, required %0d", Wraps, m_wraps);
    else passes++;
    check_drained("period");
    Segments = seg_tab[2];
    tick(2);
    Reset = 1'b0;
    tick(1);
    m_state = 0; m_wraps = 0; m_prev = 0;
    checks++;
    if ({Digit, DigitValid, Step, Skip, Zero, Invalid, Wraps, Period} !== '0)
      $display("FAIL mid_reset digit=%0d dv=%b inv=%b wraps=%0d period=%0d, required all 0",
               Digit, DigitValid, Invalid, Wraps, Period);
    else passes++;
    Reset = 1'b1;
    expect_digit(2);
    tick(8);
    check_drained("post_reset");
  endtask

  initial begin
    test_reset;
    test_count;
    test_glitch;
    test_skip_zero;
    test_invalid_clear;
    test_enable;
    test_back_to_back;
    test_period;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
